// File: rtl/hht_row_mac.sv
// Row multiply-accumulate stage for CSR SpMV: multiplies (matrix, vector) value pairs,
// sums them per row and queues {row, sum} results in a small FIFO for writeback.
module hht_row_mac #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 48,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mval,
    input  logic [DATA_W-1:0] in_vval,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0] rows_q, in_row_q, row_idx_q;
    logic             s1_valid_q, s1_last_q;
    logic [ACC_W-1:0] s1_prod_q, acc_q, prod_trunc;
    logic [ACC_W:0]   sum;
    logic             ovf_q;

    logic [ROW_W-1:0] fifo_row [FIFO_DEPTH];
    logic [ACC_W-1:0] fifo_sum [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic accept, row_end, start_ok, push, pop;

    assign accept   = in_valid && in_ready;
    assign row_end  = in_last || in_empty;
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign push     = s1_valid_q && s1_last_q;
    assign pop      = out_valid && out_ready;

    // Low ACC_W bits of the full product equal the product of ACC_W-wide operands.
    assign prod_trunc = ACC_W'(in_mval) * ACC_W'(in_vval);
    assign sum        = {1'b0, acc_q} + {1'b0, s1_prod_q};

    // A row end sitting in S1 already owns a FIFO slot, so it is counted as credit used.
    assign in_ready  = (state_q == RUN) &&
                       (({1'b0, count_q} + (CNT_W + 1)'(push)) < (CNT_W + 1)'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign out_row   = fifo_row[rd_ptr_q];
    assign out_sum   = fifo_sum[rd_ptr_q];
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign ovf       = ovf_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_rows == '0) ? DONE : RUN;
            RUN: if (accept && row_end && (in_row_q == rows_q - ROW_W'(1))) state_d = DRAIN;
            DRAIN: if (!s1_valid_q && (count_q == '0)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rows_q     <= '0;
            in_row_q   <= '0;
            row_idx_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            // NOTE: the FIFO storage is reset so out_row/out_sum read 0 out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_row[i] <= '0;
                fifo_sum[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            s1_valid_q <= accept;
            if (accept) begin
                s1_last_q <= row_end;
                s1_prod_q <= in_empty ? '0 : prod_trunc;
                if (row_end) in_row_q <= in_row_q + ROW_W'(1);
            end

            if (s1_valid_q) begin
                if (sum[ACC_W]) ovf_q <= 1'b1;
                if (s1_last_q) begin
                    fifo_row[wr_ptr_q] <= row_idx_q;
                    fifo_sum[wr_ptr_q] <= sum[ACC_W-1:0];
                    wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
                    row_idx_q          <= row_idx_q + ROW_W'(1);
                    acc_q              <= '0;
                end else begin
                    acc_q <= sum[ACC_W-1:0];
                end
            end

            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            // Start is only honoured with the pipeline idle, so it cannot collide with S2.
            if (start_ok) begin
                rows_q    <= num_rows;
                in_row_q  <= '0;
                row_idx_q <= '0;
                acc_q     <= '0;
                ovf_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hht_row_mac.sv
// Bench for hht_row_mac: directed scenarios plus randomized rows, checked against
// a per-row arithmetic reference model and an ordered queue of expected results.
module tb_hht_row_mac;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 48;
    localparam int ROW_W  = 16;
    localparam int DEPTH  = 4;
    localparam longint unsigned TWO48 = 64'h0001_0000_0000_0000;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              start = 1'b0;
    logic [ROW_W-1:0]  num_rows = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_mval = '0;
    logic [DATA_W-1:0] in_vval = '0;
    logic              in_last = 1'b0;
    logic              in_empty = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ROW_W-1:0]  out_row;
    logic [ACC_W-1:0]  out_sum;
    logic              busy;
    logic              done;
    logic              ovf;

    hht_row_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROW_W(ROW_W), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_mval(in_mval), .in_vval(in_vval),
        .in_last(in_last), .in_empty(in_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_sum(out_sum),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [ROW_W-1:0] row;
        logic [ACC_W-1:0] sum;
    } res_t;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    res_t exp_q[$];
    res_t mon_e;
    logic [ROW_W-1:0] m_row;
    longint unsigned  m_acc;
    bit               m_ovf;
    bit               rnd_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a row's sum is the mod-2^48 total of its truncated products.
    task automatic model_beat(input logic [31:0] m, input logic [31:0] v, input bit last, input bit empty);
        longint unsigned mm, vv, p;
        if (empty) begin
            exp_q.push_back('{m_row, '0});
            m_row++;
            m_acc = 0;
        end else begin
            mm = m;
            vv = v;
            p = (mm * vv) % TWO48;
            m_acc = m_acc + p;
            if (m_acc >= TWO48) begin
                m_ovf = 1'b1;
                m_acc = m_acc - TWO48;
            end
            if (last) begin
                exp_q.push_back('{m_row, m_acc[ACC_W-1:0]});
                m_row++;
                m_acc = 0;
            end
        end
    endtask

    task automatic beat(input logic [31:0] m, input logic [31:0] v, input bit last, input bit empty);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1; in_mval = m; in_vval = v; in_last = last; in_empty = empty;
        while (!ok && n < 300) begin
            @(negedge Clk);
            ok = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        if (ok) model_beat(m, v, last, empty);
        else    check("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_row(input int nb);
        if (nb == 0) beat($urandom, $urandom, 1'b0, 1'b1);
        else for (int i = 0; i < nb; i++) beat($urandom, $urandom, (i == nb - 1), 1'b0);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_rows = ROW_W'(n);
        @(posedge Clk);
        #1;
        start = 1'b0;
        m_row = '0;
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    always @(negedge Clk) begin
        if (Rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_row", out_row, mon_e.row);
                check("out_sum", out_sum, mon_e.sum);
            end
            pops++;
        end
    end

    always @(posedge Clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops_before;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_sum", out_sum, 0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        // Single row: latency and hold under backpressure.
        out_ready = 1'b0;
        do_start(1);
        check("run_busy", busy, 1);
        beat(32'd76, 32'd47, 1'b0, 1'b0);
        beat(32'd41, 32'd86, 1'b1, 1'b0);
        @(negedge Clk);
        check("lat_t1_valid", out_valid, 0);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("lat_t2_valid", out_valid, 1);
        check("single_row", out_row, 0);
        check("single_sum", out_sum, 7098);
        repeat (3) @(negedge Clk);
        check("hold_sum", out_sum, 7098);
        check("hold_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done("single");

        // Empty row between two populated rows.
        do_start(3);
        beat(32'd2, 32'd5, 1'b1, 1'b0);
        beat(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
        beat(32'd3, 32'd4, 1'b0, 1'b0);
        beat(32'd1, 32'd1, 1'b1, 1'b0);
        wait_done("empty_row");

        // Backpressure: four rows fill the FIFO credit, the rest wait for pops.
        out_ready = 1'b0;
        pops_before = pops;
        do_start(6);
        for (int i = 0; i < 4; i++) beat(32'(i + 1), 32'd3, 1'b1, 1'b0);
        @(negedge Clk);
        check("bp_ready_low", in_ready, 0);
        repeat (3) @(negedge Clk);
        check("bp_ready_still_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
        beat(32'd5, 32'd3, 1'b1, 1'b0);
        beat(32'd6, 32'd3, 1'b1, 1'b0);
        wait_done("backpressure");
        check("bp_pop_count", pops - pops_before, 6);

        // Accumulator overflow.
        do_start(1);
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done("overflow");
        check("ovf_set", ovf, 1);

        // Zero rows: straight to DONE, inputs dropped, ovf cleared.
        do_start(0);
        check("zero_done", done, 1);
        check("zero_ovf_clear", ovf, 0);
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("zero_in_ready", in_ready, 0);
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge Clk);
        check("zero_no_output", out_valid, 0);
        @(posedge Clk);
        #1;
        do_start(1);
        beat(32'd6, 32'd7, 1'b1, 1'b0);
        wait_done("restart");

        // Reset in the middle of a five-row run.
        out_ready = 1'b0;
        do_start(5);
        send_row(2);
        send_row(2);
        Rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_out_row", out_row, 0);
        check("mid_rst_out_sum", out_sum, 0);
        exp_q.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
        do_start(1);
        send_row(3);
        wait_done("post_reset");

        // Randomized rows with random consumer backpressure.
        rnd_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int nr;
            nr = 3 + int'($urandom_range(0, 3));
            do_start(nr);
            for (int k = 0; k < nr; k++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge Clk);
                    #1;
                end
                send_row(int'($urandom_range(0, 4)));
            end
            wait_done("random");
        end
        rnd_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
